// File: rtl/hs_pkg.sv
// Shared encodings for the Nios PIO block handshake: FSM states, sw commands, hw status codes.
package hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LOW = 2'd1,
        ST_HOLD     = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_WORD   = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;
    localparam logic [1:0] CMD_ABORT  = 2'b11;

    localparam logic [1:0] STS_READY  = 2'b00;
    localparam logic [1:0] STS_ACK    = 2'b01;
    localparam logic [1:0] STS_BUSY   = 2'b10;
    localparam logic [1:0] STS_ERROR  = 2'b11;

endpackage

// File: rtl/hs_block_responder_if.sv
// Bundle of the sw-facing PIO handshake and the downstream block port.
interface hs_block_responder_if #(
    parameter int WORDS = 8
);
    localparam int CW = $clog2(WORDS + 1);

    logic [15:0]         to_hw_port;
    logic [1:0]          to_hw_sig;
    logic [1:0]          to_sw_sig;
    logic [16*WORDS-1:0] block_data;
    logic                block_valid;
    logic                block_ready;
    logic [CW-1:0]       word_count;

    modport master (
        output to_hw_port, to_hw_sig, block_ready,
        input  to_sw_sig, block_data, block_valid, word_count
    );

    modport slave (
        input  to_hw_port, to_hw_sig, block_ready,
        output to_sw_sig, block_data, block_valid, word_count
    );

endinterface

// File: rtl/hs_sync.sv
// Parameterized-depth flop synchronizer, cleared by synchronous reset.
module hs_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff <= '0;
        end else begin
            r_ff[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_ff[i] <= r_ff[i-1];
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/hs_block_responder.sv
// Block assembler answering a Nios PIO word/commit/abort handshake.
// Optional WAIT_LOW watchdog compiled in with `define HS_RESP_TIMEOUT_EN.
module hs_block_responder_core
    import hs_pkg::*;
#(
    parameter int WORDS          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset,
    hs_block_responder_if.slave bus
);

    localparam int CW = $clog2(WORDS + 1);

    logic [1:0]          w_sig_s;
    state_t              r_state, w_state;
    logic [1:0]          r_sts, w_sts;
    logic                r_valid, w_valid;
    logic [CW-1:0]       r_cnt, w_cnt;
    logic                w_cap;
    logic                w_timeout;
    logic [16*WORDS-1:0] r_data;

    hs_sync #(.WIDTH(2), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.to_hw_sig),
        .o_q   (w_sig_s)
    );

`ifdef HS_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;

    // Restarts on any (re)entry to WAIT_LOW, including an ABORT while already there.
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_WAIT_LOW || w_sig_s == CMD_ABORT) r_timer <= '0;
        else if (!w_timeout)                                        r_timer <= r_timer + 1'b1;
    end

    assign w_timeout = (r_state == ST_WAIT_LOW) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_sts   = r_sts;
        w_valid = r_valid;
        w_cnt   = r_cnt;
        w_cap   = 1'b0;
        // ABORT overrides everything, including a same-cycle block_ready in HOLD.
        if (w_sig_s == CMD_ABORT) begin
            w_state = ST_WAIT_LOW;
            w_sts   = STS_READY;
            w_valid = 1'b0;
            w_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sig_s == CMD_WORD) begin
                        if (r_cnt < CW'(WORDS)) begin
                            w_cap   = 1'b1;
                            w_cnt   = r_cnt + 1'b1;
                            w_sts   = STS_ACK;
                            w_state = ST_WAIT_LOW;
                        end else begin
                            w_sts   = STS_ERROR;
                            w_state = ST_ERR;
                        end
                    end else if (w_sig_s == CMD_COMMIT) begin
                        if (r_cnt == CW'(WORDS)) begin
                            w_valid = 1'b1;
                            w_sts   = STS_BUSY;
                            w_state = ST_HOLD;
                        end else begin
                            w_sts   = STS_ERROR;
                            w_state = ST_ERR;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (w_sig_s == CMD_IDLE) begin
                        w_sts   = STS_READY;
                        w_state = ST_IDLE;
                    end else if (w_timeout) begin
                        w_sts   = STS_ERROR;
                        w_state = ST_ERR;
                    end
                end
                ST_HOLD: begin
                    if (r_valid && bus.block_ready) begin
                        w_valid = 1'b0;
                        w_cnt   = '0;
                        w_sts   = STS_ACK;
                        w_state = ST_WAIT_LOW;
                    end
                end
                default: begin
                    w_sts = STS_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sts   <= STS_READY;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_sts   <= w_sts;
            r_valid <= w_valid;
            r_cnt   <= w_cnt;
            // First word lands in the MSB slot.
            if (w_cap) begin
                for (int i = 0; i < WORDS; i++)
                    if (r_cnt == CW'(i)) r_data[16*(WORDS-1-i) +: 16] <= bus.to_hw_port;
            end
        end
    end

    assign bus.to_sw_sig   = r_sts;
    assign bus.block_valid = r_valid;
    assign bus.word_count  = r_cnt;
    assign bus.block_data  = r_data;

endmodule

module hs_block_responder #(
    parameter int WORDS          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  to_hw_port,
    input  logic [1:0]                   to_hw_sig,
    output logic [1:0]                   to_sw_sig,
    output logic [16*WORDS-1:0]          block_data,
    output logic                         block_valid,
    input  logic                         block_ready,
    output logic [$clog2(WORDS+1)-1:0]   word_count
);

    hs_block_responder_if #(.WORDS(WORDS)) u_bus ();

    assign u_bus.to_hw_port  = to_hw_port;
    assign u_bus.to_hw_sig   = to_hw_sig;
    assign u_bus.block_ready = block_ready;
    assign to_sw_sig         = u_bus.to_sw_sig;
    assign block_data        = u_bus.block_data;
    assign block_valid       = u_bus.block_valid;
    assign word_count        = u_bus.word_count;

    hs_block_responder_core #(
        .WORDS          (WORDS),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus.slave)
    );

endmodule

// File: tb/tb_hs_block_responder.sv
// Bench for hs_block_responder: vector table, directed corner sequences, randomized ops vs a queue model.
module tb_hs_block_responder;
    import hs_pkg::*;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int TO = 15;
    localparam int DW = 16 * W;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [1:0]  exp_hold;
        logic [1:0]  exp_rel;
        int          exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hs_block_responder_if #(.WORDS(W)) bus ();

    hs_block_responder #(.WORDS(W), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .to_hw_port  (bus.to_hw_port),
        .to_hw_sig   (bus.to_hw_sig),
        .to_sw_sig   (bus.to_sw_sig),
        .block_data  (bus.block_data),
        .block_valid (bus.block_valid),
        .block_ready (bus.block_ready),
        .word_count  (bus.word_count)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int vcnt = 0;

    logic [15:0]   mq[$];
    logic          merr = 1'b0;
    logic [DW-1:0] mdata = '0;
    vec_t          vecs[8];

    always @(negedge clk) if (bus.block_valid) vcnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One full sw transaction; expectations come from the queue model.
    task automatic do_op(input logic [1:0] cmd, input logic [15:0] d, input logic rdy, input string nm);
        logic [1:0] eh, er;
        logic busy_then;
        int ecnt;
        busy_then = 1'b0;
        if (cmd == CMD_ABORT) begin
            mq.delete(); merr = 1'b0; eh = STS_READY; er = STS_READY;
        end else if (merr) begin
            eh = STS_ERROR; er = STS_ERROR;
        end else if (cmd == CMD_WORD) begin
            if (mq.size() < W) begin
                mdata[DW - 16 - 16 * mq.size() +: 16] = d;
                mq.push_back(d);
                eh = STS_ACK; er = STS_READY;
            end else begin
                merr = 1'b1; eh = STS_ERROR; er = STS_ERROR;
            end
        end else if (cmd == CMD_COMMIT) begin
            if (mq.size() == W) begin
                mq.delete();
                busy_then = !rdy;
                eh = rdy ? STS_ACK : STS_BUSY; er = STS_READY;
            end else begin
                merr = 1'b1; eh = STS_ERROR; er = STS_ERROR;
            end
        end else begin
            eh = merr ? STS_ERROR : STS_READY; er = eh;
        end
        ecnt = busy_then ? W : mq.size();
        bus.to_hw_port  = d;
        bus.block_ready = (cmd == CMD_COMMIT) ? rdy : 1'b0;
        bus.to_hw_sig   = cmd;
        cyc(6);
        chk({nm, " sts"}, DW'(bus.to_sw_sig), DW'(eh));
        chk({nm, " cnt"}, DW'(bus.word_count), DW'(ecnt));
        chk({nm, " data"}, bus.block_data, mdata);
        if (busy_then) begin
            bus.block_ready = 1'b1;
            cyc(1);
            chk({nm, " late ack"}, DW'(bus.to_sw_sig), DW'(STS_ACK));
            chk({nm, " late cnt"}, DW'(bus.word_count), '0);
        end
        bus.to_hw_sig   = CMD_IDLE;
        bus.block_ready = 1'b0;
        cyc(6);
        chk({nm, " rel sts"}, DW'(bus.to_sw_sig), DW'(er));
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < W; i++) do_op(CMD_WORD, base + 16'(i), 1'b0, "fill");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        logic [1:0]    c;
        int            r;

        bus.to_hw_port = '0; bus.to_hw_sig = CMD_IDLE; bus.block_ready = 1'b0;
        vecs[0] = '{CMD_WORD,   16'h00A1, STS_ACK,   STS_READY, 1};
        vecs[1] = '{CMD_WORD,   16'h00B2, STS_ACK,   STS_READY, 2};
        vecs[2] = '{CMD_WORD,   16'h00C3, STS_ACK,   STS_READY, 3};
        vecs[3] = '{CMD_COMMIT, 16'h0000, STS_ERROR, STS_ERROR, 3};
        vecs[4] = '{CMD_WORD,   16'h00D4, STS_ERROR, STS_ERROR, 3};
        vecs[5] = '{CMD_ABORT,  16'h0000, STS_READY, STS_READY, 0};
        vecs[6] = '{CMD_COMMIT, 16'h0000, STS_ERROR, STS_ERROR, 0};
        vecs[7] = '{CMD_ABORT,  16'h0000, STS_READY, STS_READY, 0};

        cyc(3);
        chk("reset sts",   DW'(bus.to_sw_sig),   DW'(STS_READY));
        chk("reset valid", DW'(bus.block_valid), '0);
        chk("reset cnt",   DW'(bus.word_count),  '0);
        chk("reset data",  bus.block_data,       '0);
        reset = 1'b0;
        cyc(2);

        // Status must move exactly SS+1 edges after the pin.
        bus.to_hw_port = 16'h1111; bus.to_hw_sig = CMD_WORD;
        cyc(SS);
        chk("latency early", DW'(bus.to_sw_sig), DW'(STS_READY));
        cyc(1);
        chk("latency ack",   DW'(bus.to_sw_sig), DW'(STS_ACK));
        bus.to_hw_sig = CMD_IDLE;
        cyc(6);
        mdata[DW-16 +: 16] = 16'h1111;
        do_op(CMD_ABORT, 16'h0, 1'b0, "abort1");

        // Eight words then a commit with the consumer ready.
        for (int i = 1; i <= W; i++) do_op(CMD_WORD, 16'(i), 1'b0, "w035");
        vcnt = 0;
        do_op(CMD_COMMIT, 16'h0, 1'b1, "c035");
        chk("req035 block", bus.block_data, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
        chk("req035 pulse", DW'(vcnt), DW'(1));

        for (int i = 0; i < 8; i++) begin
            bus.to_hw_port = vecs[i].data; bus.to_hw_sig = vecs[i].cmd;
            cyc(6);
            if (vecs[i].cmd == CMD_WORD && vecs[i].exp_hold == STS_ACK)
                mdata[DW - 16 * vecs[i].exp_cnt +: 16] = vecs[i].data;
            chk($sformatf("vec%0d hold", i), DW'(bus.to_sw_sig),  DW'(vecs[i].exp_hold));
            chk($sformatf("vec%0d cnt", i),  DW'(bus.word_count), DW'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d data", i), bus.block_data,      mdata);
            bus.to_hw_sig = CMD_IDLE;
            cyc(6);
            chk($sformatf("vec%0d rel", i),  DW'(bus.to_sw_sig),  DW'(vecs[i].exp_rel));
        end

        // Consumer stalls 50 clks in HOLD.
        fill(16'h0100);
        bus.to_hw_sig = CMD_COMMIT;
        cyc(3);
        chk("hold busy", DW'(bus.to_sw_sig), DW'(STS_BUSY));
        held = mdata;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("stall sts",  DW'(bus.to_sw_sig), DW'(STS_BUSY));
            chk("stall data", bus.block_data,     held);
        end
        bus.block_ready = 1'b1;
        cyc(1);
        chk("stall ack",   DW'(bus.to_sw_sig),   DW'(STS_ACK));
        chk("stall valid", DW'(bus.block_valid), '0);
        mq.delete();
        bus.to_hw_sig = CMD_IDLE; bus.block_ready = 1'b0;
        cyc(6);
        chk("stall rel", DW'(bus.to_sw_sig), DW'(STS_READY));

        // Ninth word is refused.
        fill(16'h0200);
        do_op(CMD_WORD, 16'hDEAD, 1'b0, "ninth");
        do_op(CMD_ABORT, 16'h0, 1'b0, "abort9");

        // ABORT and block_ready land on the same edge: block withdrawn.
        fill(16'h0300);
        bus.to_hw_sig = CMD_COMMIT;
        cyc(3);
        bus.to_hw_sig = CMD_ABORT;
        cyc(SS);
        bus.block_ready = 1'b1;
        cyc(1);
        chk("abort prio sts",   DW'(bus.to_sw_sig),   DW'(STS_READY));
        chk("abort prio valid", DW'(bus.block_valid), '0);
        chk("abort prio cnt",   DW'(bus.word_count),  '0);
        mq.delete(); merr = 1'b0;
        bus.to_hw_sig = CMD_IDLE; bus.block_ready = 1'b0;
        cyc(6);
        chk("abort prio rel", DW'(bus.to_sw_sig), DW'(STS_READY));

        // Reset while holding a block.
        fill(16'h0400);
        bus.to_hw_sig = CMD_COMMIT;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("hold rst sts",   DW'(bus.to_sw_sig),   DW'(STS_READY));
        chk("hold rst valid", DW'(bus.block_valid), '0);
        chk("hold rst cnt",   DW'(bus.word_count),  '0);
        chk("hold rst data",  bus.block_data,       '0);
        bus.to_hw_sig = CMD_IDLE;
        reset = 1'b0;
        mq.delete(); merr = 1'b0; mdata = '0;
        cyc(6);
        chk("post rst sts", DW'(bus.to_sw_sig), DW'(STS_READY));

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (merr)                c = (r < 50) ? CMD_ABORT : 2'($urandom_range(0, 2));
            else if (mq.size() == W) c = (r < 70) ? CMD_COMMIT : ((r < 85) ? CMD_WORD : CMD_ABORT);
            else                     c = (r < 80) ? CMD_WORD : ((r < 88) ? CMD_COMMIT : ((r < 95) ? CMD_ABORT : CMD_IDLE));
            do_op(c, 16'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

`ifdef HS_RESP_TIMEOUT_EN
        do_op(CMD_ABORT, 16'h0, 1'b0, "pre wd");
        bus.to_hw_port = 16'h0BEE; bus.to_hw_sig = CMD_WORD;
        cyc(SS + 1);
        chk("wd ack", DW'(bus.to_sw_sig), DW'(STS_ACK));
        cyc(20);
        chk("wd timeout", DW'(bus.to_sw_sig), DW'(STS_ERROR));
        mdata[DW-16 +: 16] = 16'h0BEE;
        bus.to_hw_sig = CMD_IDLE;
        cyc(6);
        do_op(CMD_ABORT, 16'h0, 1'b0, "wd abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
